// File: rtl/ebus_if.sv
// Peripheral-side E-bus signal bundle between the CPU bridge/clock generator and ebus_ctrl.
interface ebus_if;
    logic       clk7_en;
    logic [9:0] eclk;
    logic       req;
    logic       rnw;
    logic [7:0] wdata;
    logic [7:0] pdata;
    logic       e;
    logic       vma;
    logic       cs;
    logic       we;
    logic [7:0] wdata_out;
    logic [7:0] rdata;
    logic       ack;
    logic       busy;

    modport master (
        output clk7_en, eclk, req, rnw, wdata, pdata,
        input  e, vma, cs, we, wdata_out, rdata, ack, busy
    );

    modport slave (
        input  clk7_en, eclk, req, rnw, wdata, pdata,
        output e, vma, cs, we, wdata_out, rdata, ack, busy
    );
endinterface

// File: rtl/ebus_ctrl.sv
// 6800-style peripheral access sequencer aligned to the 10-phase E clock.
// Optional access counter output ecnt when EBUS_CNT_EN is defined.
module ebus_ctrl (
    input  logic        clk_28,
    input  logic        reset,
    ebus_if.slave       bus
`ifdef EBUS_CNT_EN
    ,
    output logic [15:0] ecnt
`endif
);

    typedef enum logic [2:0] {StIdle, StSync, StVma, StAct, StDone} state_e;

    state_e     state_q, state_d;
    logic       e_q, e_d;
    logic       vma_q, vma_d;
    logic       cs_q, cs_d;
    logic       we_q, we_d;
    logic       rnw_q, rnw_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       ack_q, ack_d;
    logic       busy_q, busy_d;

    logic [3:0] phase;
    logic       phase_ok;
    logic       step;

    // Anything other than exactly one set bit stalls the sequencer.
    always_comb begin
        phase = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (bus.eclk[i]) phase = 4'(i);
        end
        phase_ok = $onehot(bus.eclk);
    end

    assign step = bus.clk7_en && phase_ok;

    always_comb begin
        state_d = state_q;
        e_d     = e_q;
        vma_d   = vma_q;
        cs_d    = cs_q;
        we_d    = we_q;
        rnw_d   = rnw_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        busy_d  = busy_q;

        if (bus.clk7_en) e_d = phase_ok && (phase >= 4'd6);

        unique case (state_q)
            StIdle: begin
                if (step && bus.req) begin
                    rnw_d   = bus.rnw;
                    wdata_d = bus.wdata;
                    busy_d  = 1'b1;
                    state_d = StSync;
                end
            end
            StSync: begin
                if (step && phase == 4'd4) begin
                    vma_d   = 1'b1;
                    state_d = StVma;
                end
            end
            StVma: begin
                if (step && phase == 4'd6) begin
                    cs_d    = 1'b1;
                    we_d    = ~rnw_q;
                    state_d = StAct;
                end
            end
            StAct: begin
                if (step && phase == 4'd9) begin
                    if (rnw_q) rdata_d = bus.pdata;
                end else if (step && phase == 4'd0) begin
                    cs_d    = 1'b0;
                    we_d    = 1'b0;
                    vma_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (step && !bus.req) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_28 or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            e_q     <= 1'b0;
            vma_q   <= 1'b0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            rnw_q   <= 1'b0;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            e_q     <= e_d;
            vma_q   <= vma_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            rnw_q   <= rnw_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.e         = e_q;
    assign bus.vma       = vma_q;
    assign bus.cs        = cs_q;
    assign bus.we        = we_q;
    assign bus.wdata_out = wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.ack       = ack_q;
    assign bus.busy      = busy_q;

`ifdef EBUS_CNT_EN
    logic [15:0] cnt_q;

    // Counts in step with the ack edge; wraps naturally at 16 bits.
    always_ff @(posedge clk_28 or posedge reset) begin
        if (reset) begin
            cnt_q <= 16'h0000;
        end else if (ack_d) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign ecnt = cnt_q;
`endif

endmodule

// File: tb/tb_ebus_ctrl.sv
// Directed bench for ebus_ctrl: read/write alignment, held req, mid-access reset, eclk stall.
module tb_ebus_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    ebus_if bus ();

`ifdef EBUS_CNT_EN
    logic [15:0] ecnt;
`endif

    ebus_ctrl dut (
        .clk_28 (clk),
        .reset  (reset),
        .bus    (bus)
`ifdef EBUS_CNT_EN
        ,
        .ecnt   (ecnt)
`endif
    );

    int   checks = 0;
    int   errors = 0;
    int   ph = 0;
    int   ack_cycles = 0;
    logic eclk_zero = 1'b0;

    logic       s_e, s_vma, s_cs, s_we, s_ack, s_busy;
    logic [7:0] s_wdo, s_rdata;

    int lat, vma_ph, cs_ph, cs_len, vma_len, bad, ack_delta;

    always @(negedge clk) begin
        if (bus.ack === 1'b1) ack_cycles <= ack_cycles + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 7 MHz period: clk7_en high for one clk_28 cycle at the current phase.
    task automatic period();
        @(negedge clk);
        bus.clk7_en = 1'b1;
        bus.eclk    = eclk_zero ? 10'd0 : (10'd1 << ph);
        @(negedge clk);
        bus.clk7_en = 1'b0;
        s_e     = bus.e;
        s_vma   = bus.vma;
        s_cs    = bus.cs;
        s_we    = bus.we;
        s_ack   = bus.ack;
        s_busy  = bus.busy;
        s_wdo   = bus.wdata_out;
        s_rdata = bus.rdata;
        chk("e_level", 32'(s_e), 32'(!reset && !eclk_zero && ph >= 6));
        @(negedge clk);
        @(negedge clk);
        if (!eclk_zero) ph = (ph == 9) ? 0 : ph + 1;
    endtask

    task automatic go_to(input int p);
        while (ph != p) period();
    endtask

    function automatic int exp_lat(input int p);
        return (p < 4) ? (4 - p) + 6 : (14 - p) + 6;
    endfunction

    task automatic wait_ack(input logic exp_we, input logic [7:0] exp_data);
        int  a0;
        int  p;
        logic seen;
        a0 = ack_cycles;
        lat = 0; vma_ph = -1; cs_ph = -1; cs_len = 0; vma_len = 0; bad = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            p = ph;
            period();
            lat++;
            if (s_vma && vma_ph < 0) vma_ph = p;
            if (s_cs && cs_ph < 0) cs_ph = p;
            if (s_vma) vma_len++;
            if (s_cs) cs_len++;
            if (s_cs && (s_we !== exp_we || s_wdo !== exp_data)) bad++;
            if (s_ack) seen = 1'b1;
        end
        ack_delta = ack_cycles - a0;
    endtask

    task automatic check_access(input string pfx, input int elat);
        chk({pfx, "_latency"}, 32'(lat), 32'(elat));
        chk({pfx, "_vma_phase"}, 32'(vma_ph), 32'd4);
        chk({pfx, "_cs_phase"}, 32'(cs_ph), 32'd6);
        chk({pfx, "_cs_len"}, 32'(cs_len), 32'd4);
        chk({pfx, "_vma_len"}, 32'(vma_len), 32'd6);
        chk({pfx, "_we_wdata_window"}, 32'(bad), 32'd0);
        chk({pfx, "_ack_cycles"}, 32'(ack_delta), 32'd1);
        chk({pfx, "_cs_at_ack"}, 32'(s_cs), 32'd0);
        chk({pfx, "_vma_at_ack"}, 32'(s_vma), 32'd0);
    endtask

    initial begin
        int pa;
        int busy_low;
        int vma_hi;
        int a0;

        bus.clk7_en = 1'b0;
        bus.eclk    = 10'd1;
        bus.req     = 1'b0;
        bus.rnw     = 1'b1;
        bus.wdata   = 8'h00;
        bus.pdata   = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_e", 32'(bus.e), 32'd0);
        chk("rst_vma", 32'(bus.vma), 32'd0);
        chk("rst_cs", 32'(bus.cs), 32'd0);
        chk("rst_we", 32'(bus.we), 32'd0);
        chk("rst_wdata_out", 32'(bus.wdata_out), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;

        // Read accepted at phase 3
        go_to(3);
        bus.req = 1'b1; bus.rnw = 1'b1; bus.wdata = 8'h00; bus.pdata = 8'h5A;
        period();
        chk("t1_busy_accept", 32'(s_busy), 32'd1);
        chk("t1_vma_accept", 32'(s_vma), 32'd0);
        wait_ack(1'b0, 8'h00);
        check_access("t1", 7);
        chk("t1_rdata", 32'(s_rdata), 32'h5A);
        bus.req = 1'b0;
        period();
        chk("t1_busy_idle", 32'(s_busy), 32'd0);

        // Write accepted at phase 5 waits a full E cycle for vma
        go_to(5);
        bus.req = 1'b1; bus.rnw = 1'b0; bus.wdata = 8'hC3; bus.pdata = 8'hEE;
        period();
        chk("t2_busy_accept", 32'(s_busy), 32'd1);
        chk("t2_wdata_out", 32'(s_wdo), 32'hC3);
        wait_ack(1'b1, 8'hC3);
        check_access("t2", 15);
        chk("t2_rdata_hold", 32'(s_rdata), 32'h5A);

        // req held after ack: single access, busy stays high
        a0 = ack_cycles; busy_low = 0; vma_hi = 0;
        repeat (20) begin
            period();
            if (!s_busy) busy_low++;
            if (s_vma) vma_hi++;
        end
        chk("t3_busy_held", 32'(busy_low), 32'd0);
        chk("t3_no_vma", 32'(vma_hi), 32'd0);
        chk("t3_no_ack", 32'(ack_cycles - a0), 32'd0);
        bus.req = 1'b0;
        period();
        chk("t3_busy_drop", 32'(s_busy), 32'd0);
        bus.req = 1'b1; bus.rnw = 1'b1; bus.wdata = 8'h00; bus.pdata = 8'h3C;
        pa = ph;
        period();
        chk("t3_reaccept", 32'(s_busy), 32'd1);
        wait_ack(1'b0, 8'h00);
        check_access("t3", exp_lat(pa));
        chk("t3_rdata", 32'(s_rdata), 32'h3C);
        bus.req = 1'b0;
        period();

        // Reset asserted while in ACT
        go_to(2);
        bus.req = 1'b1; bus.rnw = 1'b1; bus.pdata = 8'h77;
        period();
        repeat (5) period();
        chk("t4_in_act_cs", 32'(s_cs), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t4_rst_e", 32'(bus.e), 32'd0);
        chk("t4_rst_vma", 32'(bus.vma), 32'd0);
        chk("t4_rst_cs", 32'(bus.cs), 32'd0);
        chk("t4_rst_we", 32'(bus.we), 32'd0);
        chk("t4_rst_rdata", 32'(bus.rdata), 32'd0);
        chk("t4_rst_busy", 32'(bus.busy), 32'd0);
        a0 = ack_cycles;
        bus.req = 1'b0;
        repeat (3) period();
        chk("t4_no_ack", 32'(ack_cycles - a0), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.req = 1'b1; bus.pdata = 8'h96;
        pa = ph;
        period();
        chk("t4_reaccept", 32'(s_busy), 32'd1);
        wait_ack(1'b0, 8'h00);
        check_access("t4", exp_lat(pa));
        chk("t4_rdata", 32'(s_rdata), 32'h96);
        bus.req = 1'b0;
        period();

        // eclk all-zero while waiting in SYNC
        go_to(5);
        bus.req = 1'b1; bus.rnw = 1'b1; bus.pdata = 8'hA5;
        period();
        eclk_zero = 1'b1;
        busy_low = 0; vma_hi = 0;
        repeat (8) begin
            period();
            if (!s_busy) busy_low++;
            if (s_vma) vma_hi++;
        end
        chk("t5_stall_busy", 32'(busy_low), 32'd0);
        chk("t5_stall_vma", 32'(vma_hi), 32'd0);
        eclk_zero = 1'b0;
        wait_ack(1'b0, 8'h00);
        check_access("t5", exp_lat(5));
        chk("t5_rdata", 32'(s_rdata), 32'hA5);
        bus.req = 1'b0;
        period();
        chk("t5_busy_idle", 32'(s_busy), 32'd0);

`ifdef EBUS_CNT_EN
        chk("cnt_after_reset", 32'(ecnt), 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ebus_ctrl.md
# ebus_ctrl

Synchronous 6800-style peripheral bus sequencer for the CIA/E-clock domain. It accepts a single peripheral access request from the CPU interface and aligns it to the 10-phase E-clock produced by the clock generator. It drives VMA, chip select and write strobe, then returns read data with a one-cycle acknowledge. The block sits between the CPU bus bridge and the CIA pair, in the clk_28 domain.

## Interface
- No parameters.
- clk_28  in  1  28 MHz system clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- clk7_en  in  1  7 MHz clock enable; one clk_28 cycle in four
- eclk  in  10  one-hot E-phase vector from the clock generator; advances once per 7 MHz cycle; all-zero is invalid
- req  in  1  access request level, held until ack
- rnw  in  1  1 = read, 0 = write; sampled with req in IDLE
- wdata  in  8  write data; sampled with req in IDLE
- pdata  in  8  peripheral read data
- e  out  1  E-clock level: 1 when phase is 6..9
- vma  out  1  valid memory address, active-high
- cs  out  1  peripheral select
- we  out  1  write strobe, valid only while cs=1
- wdata_out  out  8  registered write data
- rdata  out  8  latched read data, valid on ack
- ack  out  1  one-clk_28-cycle completion pulse
- busy  out  1  1 from request acceptance to return to IDLE

## Operation
- Phase p = index of the set bit of eclk, evaluated only on cycles with clk7_en=1. With eclk all-zero, nothing advances and e=0.
- States: IDLE, SYNC, VMA, ACT, DONE.
- IDLE: on clk7_en with req=1, latch rnw and wdata, set busy, go SYNC.
- SYNC: on clk7_en with p==4, assert vma, go VMA. A request accepted at p==4 waits for the next p==4, since VMA requires one full phase before entry.
- VMA: on clk7_en with p==6, assert cs, set we=~rnw, go ACT.
- ACT: on clk7_en with p==9, latch pdata into rdata on reads; rdata holds its previous value on writes. On the next clk7_en (p==0), deassert cs, we and vma, pulse ack for one clk_28 cycle, go DONE.
- DONE: stay while req=1. When req=0, clear busy and go IDLE. This gives exactly one access per request.
- e is registered from p on clk7_en, independent of state.
- req dropping before ack has no effect: the cycle completes and ack is still pulsed.
- The phase checks are exact matches. If eclk is not one-hot, the FSM stalls in its current state until a valid phase appears.
- Reset mid-cycle aborts the access immediately; no ack is issued.

## Timing
- Reset values: e=0, vma=0, cs=0, we=0, wdata_out=0, rdata=0, ack=0, busy=0, state IDLE.
- All outputs are registered and change on the clk_28 edge of the clk7_en cycle that causes the transition.
- busy rises on the same edge as acceptance.
- cs is high for exactly 4 clk7_en periods (phases 6..9, 16 clk_28 cycles).
- vma leads cs by 2 clk7_en periods and falls on the same edge as cs.
- Latency from acceptance to ack is 7 to 16 clk7_en periods, depending on the phase at acceptance.
- The earliest next acceptance is on the first clk7_en after the edge where busy falls.

## Configuration
- EBUS_CNT_EN defined: adds output ecnt [15:0], which counts completed accesses.
  - Increments on each ack and wraps 0xFFFF to 0x0000.
  - Reset value 0.
- EBUS_CNT_EN undefined: no counter logic and no ecnt port.

## Test plan
- Read accepted at p=3, pdata=0x5A:
  - vma rises at p=4 and cs rises at p=6, with we=0.
  - At p=0, rdata=0x5A and ack=1 for 1 cycle.
  - Latency is 7 clk7_en periods.
- Write accepted at p=5, wdata=0xC3:
  - vma is delayed until the next p=4.
  - we=1 and wdata_out=0xC3 for the whole cs window.
  - Latency is 15 clk7_en periods.
- req held high after ack for 20 clk7_en periods:
  - Exactly one access and busy stays 1.
  - After req falls, busy drops and a new req is accepted.
- Reset asserted while in ACT:
  - All outputs go to 0 asynchronously and no ack is issued.
  - After release, a new read completes normally.
- eclk forced to 0 for 8 clk7_en periods during SYNC:
  - FSM holds in SYNC and e=0.
  - When eclk resumes, vma asserts at the next p=4.
- With EBUS_CNT_EN defined, 65537 back-to-back reads make ecnt read 0x0001.
